qeciphy_rx_frame_align: RTL and testbench
=========================================

// Module: qeciphy_rx_frame_align
//
// PURPOSE
//  Frame aligner directly upstream of the RX data monitor. It receives the
//  raw 64-bit word stream from the RX datapath and hunts for the Frame
//  Alignment Word (FAW). It then confirms the frame period and, once locked,
//  drives faw_boundary/crc_boundary, aligned word-for-word with the
//  re-registered data. locked_o is the monitor's enable.
//
// PARAMETERS
//  GROUPS       9  CRC groups per frame; each group = 1 CRC/VW word + 6 data
//                  words. FRAME_LEN = 1 + 7*GROUPS (64 by default).
//  VERIFY_HITS  3  consecutive on-period FAWs (incl. first find) to lock.
//  LOSS_MISSES  4  consecutive on-period FAW misses in LOCKED to drop lock.
//
// PORTS
//  clk_i            in   1   single clock
//  rst_i            in   1   synchronous, active-high reset
//  tdata_i          in   64  raw RX word, one per cycle, no valid qualifier
//  relock_i         in   1   force return to HUNT (e.g. monitor error)
//  tdata_o          out  64  tdata_i delayed exactly 1 cycle
//  faw_boundary_o   out  1   tdata_o is at frame offset 0 (FAW slot)
//  crc_boundary_o   out  1   tdata_o is at offset 1+7k, k=0..GROUPS-1
//  locked_o         out  1   aligner in LOCKED; monitor enable
//  align_state_o    out  2   0=HUNT 1=VERIFY 2=LOCKED
//
// BEHAVIOUR
//  - All outputs registered. Reset: tdata_o=0, boundaries=0, locked_o=0,
//    state=HUNT, offset=0, hit/miss counters=0.
//  - Offset counter is $clog2(FRAME_LEN) bits. It advances every cycle
//    outside HUNT and wraps FRAME_LEN-1 -> 0. Offset 0 is the FAW slot.
//  - HUNT: every word is tested with is_faw(). On a hit: offset<=1,
//    hit_cnt<=1, go to VERIFY. No boundaries are emitted in HUNT.
//  - VERIFY: only the word at offset 0 is tested.
//    - FAW present: hit_cnt++. When hit_cnt reaches VERIFY_HITS, go to
//      LOCKED.
//    - FAW absent: go to HUNT. The missed word is not re-examined; hunting
//      resumes on the next word.
//    - No boundaries are emitted in VERIFY.
//  - Lock entry: the confirming FAW word appears on tdata_o with
//    faw_boundary_o=1 and locked_o=1 in the same cycle.
//  - LOCKED: faw_boundary_o and crc_boundary_o are emitted purely by offset,
//    whether or not the word is a valid FAW. The downstream monitor
//    therefore sees bad FAWs and flags its own error.
//    - FAW hit at offset 0: miss_cnt<=0.
//    - FAW miss at offset 0: miss_cnt++. When miss_cnt reaches LOSS_MISSES,
//      go to HUNT. The word that causes the drop is still emitted with
//      faw_boundary_o=1 and locked_o=1. locked_o falls on the next cycle.
//  - relock_i: overrides all transitions and takes effect on the next
//    cycle: state=HUNT, counters cleared, locked_o=0, no boundaries.
//    - relock_i held high keeps the block in HUNT and suppresses FAW
//      search.
//    - relock_i coinciding with a lock-confirming FAW: relock wins.
//  - Mid-operation reset behaves the same as power-on reset. Outputs take
//    reset values in the cycle after rst_i is sampled high.
//  - faw_boundary_o and crc_boundary_o are never high in the same cycle.
//
// CONFIGURATION
//  QECIPHY_RX_ALIGN_STATS_EN
//    Defined: adds outputs
//      lock_loss_cnt_o[15:0]  LOCKED->HUNT transitions, including those
//                             caused by relock_i
//      faw_miss_cnt_o[15:0]   FAW misses detected in LOCKED
//    Both counters saturate at 16'hFFFF and are cleared by rst_i only.
//    Not defined: these ports and counters do not exist; all other
//    behaviour is identical.
//
// STRUCTURE
//  - qeciphy_pkg holds is_faw() (reused) and the additions for this block:
//    - qeciphy_align_state_t enum (HUNT/VERIFY/LOCKED)
//    - QECIPHY_CRC_GROUP_LEN = 7
//  - One sub-module, qeciphy_sat_counter (WIDTH param, inc_i, count_o),
//    instantiated twice under the macro. FSM and offset counter are inline.
//
// TESTING
//  1. Clean stream, FAW every 64 words from word 10: the 3rd FAW (word
//     138) is output with locked_o=1 and faw_boundary_o=1. crc_boundary_o
//     follows at offsets 1, 8, ..., 57. tdata_o == tdata_i delayed 1.
//  2. Fake FAW at word 5, real FAWs every 64 from word 20: VERIFY fails
//     at word 69 and returns to HUNT. Lock is reached on the FAW at word
//     212 (1st=84, 3rd=212).
//  3. Locked, then 3 corrupted FAWs followed by a good one: stays LOCKED,
//     faw_boundary_o pulses on every slot, miss_cnt resets to 0.
//  4. Locked, then 4 consecutive corrupted FAWs: locked_o drops the cycle
//     after the 4th. Stats build: lock_loss_cnt_o=1, faw_miss_cnt_o=4.
//  5. relock_i pulsed in the same cycle as the confirming FAW:
//     locked_o stays 0 and align_state_o=HUNT next cycle.
//  6. rst_i asserted for 1 cycle while LOCKED: all outputs return to reset
//     values. Relock takes exactly 2 further frame periods after the next
//     FAW.

Source files
------------

// File: rtl/qeciphy_pkg.sv
// Shared QECi PHY definitions: FAW detection, CRC group length and the
// frame-aligner state encoding.
package qeciphy_pkg;

  localparam logic [63:0] QECIPHY_FAW = 64'hD5C3_A5F0_0F5A_3C5D;

  localparam int unsigned QECIPHY_CRC_GROUP_LEN = 7;

  typedef enum logic [1:0] {
    QECIPHY_ALIGN_HUNT   = 2'd0,
    QECIPHY_ALIGN_VERIFY = 2'd1,
    QECIPHY_ALIGN_LOCKED = 2'd2
  } qeciphy_align_state_t;

  function automatic logic is_faw(input logic [63:0] word);
    return word == QECIPHY_FAW;
  endfunction

endpackage

// File: rtl/qeciphy_sat_counter.sv
// Saturating event counter, cleared only by synchronous reset.
module qeciphy_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/qeciphy_rx_frame_align.sv
// RX frame aligner: hunts for the FAW, verifies the frame period, then marks
// FAW/CRC word boundaries. QECIPHY_RX_ALIGN_STATS_EN adds lock-loss/miss counters.
module qeciphy_rx_frame_align
  import qeciphy_pkg::*;
#(
  parameter int unsigned GROUPS      = 9,
  parameter int unsigned VERIFY_HITS = 3,
  parameter int unsigned LOSS_MISSES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] tdata_i,
  input  logic        relock_i,
  output logic [63:0] tdata_o,
  output logic        faw_boundary_o,
  output logic        crc_boundary_o,
  output logic        locked_o,
  output logic [1:0]  align_state_o
`ifdef QECIPHY_RX_ALIGN_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt_o,
  output logic [15:0] faw_miss_cnt_o
`endif
);

  localparam int unsigned FRAME_LEN = 1 + QECIPHY_CRC_GROUP_LEN * GROUPS;
  localparam int unsigned OFF_W     = $clog2(FRAME_LEN);
  localparam int unsigned HIT_W     = $clog2(VERIFY_HITS + 1);
  localparam int unsigned MISS_W    = $clog2(LOSS_MISSES + 1);

  qeciphy_align_state_t state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d, off_next;
  logic [HIT_W-1:0]  hit_q, hit_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [63:0]       tdata_q;
  logic              faw_q, faw_d, crc_q, crc_d, lock_q, lock_d;
  logic              faw_hit, at_faw, at_crc;

  function automatic logic is_crc_slot(input logic [OFF_W-1:0] off);
    logic r;
    r = 1'b0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      if (off == OFF_W'(1 + k * QECIPHY_CRC_GROUP_LEN)) r = 1'b1;
    end
    return r;
  endfunction

  assign faw_hit  = is_faw(tdata_i);
  assign at_faw   = (off_q == '0);
  assign at_crc   = is_crc_slot(off_q);
  assign off_next = (off_q == OFF_W'(FRAME_LEN - 1)) ? '0 : off_q + 1'b1;

  // Boundary/lock outputs describe the word being registered this cycle, so
  // the confirming FAW and the dropping FAW both leave with locked_o high.
  always_comb begin
    state_d = state_q;
    off_d   = (state_q == QECIPHY_ALIGN_HUNT) ? off_q : off_next;
    hit_d   = hit_q;
    miss_d  = miss_q;
    faw_d   = 1'b0;
    crc_d   = 1'b0;
    lock_d  = 1'b0;
    if (relock_i) begin
      state_d = QECIPHY_ALIGN_HUNT;
      off_d   = '0;
      hit_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        QECIPHY_ALIGN_HUNT: begin
          if (faw_hit) begin
            state_d = QECIPHY_ALIGN_VERIFY;
            off_d   = OFF_W'(1);
            hit_d   = HIT_W'(1);
          end
        end
        QECIPHY_ALIGN_VERIFY: begin
          if (at_faw) begin
            if (!faw_hit) begin
              state_d = QECIPHY_ALIGN_HUNT;
              off_d   = '0;
              hit_d   = '0;
            end else if (hit_q == HIT_W'(VERIFY_HITS - 1)) begin
              state_d = QECIPHY_ALIGN_LOCKED;
              hit_d   = '0;
              miss_d  = '0;
              faw_d   = 1'b1;
              lock_d  = 1'b1;
            end else begin
              hit_d = hit_q + 1'b1;
            end
          end
        end
        QECIPHY_ALIGN_LOCKED: begin
          lock_d = 1'b1;
          faw_d  = at_faw;
          crc_d  = at_crc;
          if (at_faw) begin
            if (faw_hit) begin
              miss_d = '0;
            end else if (miss_q == MISS_W'(LOSS_MISSES - 1)) begin
              state_d = QECIPHY_ALIGN_HUNT;
              off_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = QECIPHY_ALIGN_HUNT;
          off_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= QECIPHY_ALIGN_HUNT;
      off_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      tdata_q <= '0;
      faw_q   <= 1'b0;
      crc_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      tdata_q <= tdata_i;
      faw_q   <= faw_d;
      crc_q   <= crc_d;
      lock_q  <= lock_d;
    end
  end

  assign tdata_o        = tdata_q;
  assign faw_boundary_o = faw_q;
  assign crc_boundary_o = crc_q;
  assign locked_o       = lock_q;
  assign align_state_o  = state_q;

`ifdef QECIPHY_RX_ALIGN_STATS_EN
  logic lock_loss_inc, faw_miss_inc;

  assign lock_loss_inc = (state_q == QECIPHY_ALIGN_LOCKED) && (state_d == QECIPHY_ALIGN_HUNT);
  assign faw_miss_inc  = (state_q == QECIPHY_ALIGN_LOCKED) && at_faw && !faw_hit;

  qeciphy_sat_counter #(.WIDTH(16)) u_lock_loss_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (lock_loss_inc),
    .count_o (lock_loss_cnt_o)
  );

  qeciphy_sat_counter #(.WIDTH(16)) u_faw_miss_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (faw_miss_inc),
    .count_o (faw_miss_cnt_o)
  );
`endif

endmodule

// File: tb/tb_qeciphy_rx_frame_align.sv
// Randomized bench for qeciphy_rx_frame_align against a frame-phase reference model.
module tb_qeciphy_rx_frame_align;
  import qeciphy_pkg::*;

  localparam int FL = 64;
  localparam int VH = 3;
  localparam int LM = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        relock_i = 1'b0;
  logic [63:0] tdata_i = '0;
  logic [63:0] tdata_o;
  logic        faw_boundary_o, crc_boundary_o, locked_o;
  logic [1:0]  align_state_o;
`ifdef QECIPHY_RX_ALIGN_STATS_EN
  logic [15:0] lock_loss_cnt_o, faw_miss_cnt_o;
`endif

  qeciphy_rx_frame_align #(.GROUPS(9), .VERIFY_HITS(3), .LOSS_MISSES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tdata_i        (tdata_i),
    .relock_i       (relock_i),
    .tdata_o        (tdata_o),
    .faw_boundary_o (faw_boundary_o),
    .crc_boundary_o (crc_boundary_o),
    .locked_o       (locked_o),
    .align_state_o  (align_state_o)
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    ,
    .lock_loss_cnt_o (lock_loss_cnt_o),
    .faw_miss_cnt_o  (faw_miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0/1/2 = hunting/verifying/locked; frame phase is
  // the distance in words from the anchoring FAW, modulo the frame length.
  int m_mode = 0, m_anchor = 0, m_hits = 0, m_misses = 0, m_lost = 0, m_fmiss = 0, g = 0;
  logic [63:0] e_data;
  logic        e_fb, e_cb, e_lk;
  int          e_state;

  task automatic model(input logic [63:0] w, input logic r, input logic rs);
    int pos;
    bit hit;
    hit    = (w == QECIPHY_FAW);
    pos    = (g - m_anchor) % FL;
    e_data = w;
    e_fb   = 1'b0;
    e_cb   = 1'b0;
    e_lk   = 1'b0;
    if (rs) begin
      m_mode = 0; m_hits = 0; m_misses = 0; m_lost = 0; m_fmiss = 0;
      e_data = '0;
    end else begin
      if (m_mode == 2 && pos == 0 && !hit) m_fmiss++;
      if (r) begin
        if (m_mode == 2) m_lost++;
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (hit) begin m_mode = 1; m_anchor = g; m_hits = 1; end
          1: if (pos == 0) begin
               if (!hit) m_mode = 0;
               else begin
                 m_hits++;
                 if (m_hits == VH) begin m_mode = 2; m_misses = 0; e_lk = 1'b1; e_fb = 1'b1; end
               end
             end
          default: begin
            e_lk = 1'b1;
            e_fb = (pos == 0);
            e_cb = (pos != 0) && ((pos - 1) % 7 == 0);
            if (pos == 0) begin
              if (hit) m_misses = 0;
              else begin
                m_misses++;
                if (m_misses == LM) begin m_mode = 0; m_lost++; end
              end
            end
          end
        endcase
      end
    end
    e_state = m_mode;
    g++;
  endtask

  int   last_rise, last_fall;
  logic prev_lk;

  task automatic step(input int idx, input logic [63:0] w, input logic r, input logic rs);
    @(negedge clk);
    tdata_i  = w;
    relock_i = r;
    rst_i    = rs;
    model(w, r, rs);
    @(posedge clk);
    #1;
    check("tdata", tdata_o, e_data);
    check("faw_bnd", faw_boundary_o, e_fb);
    check("crc_bnd", crc_boundary_o, e_cb);
    check("locked", locked_o, e_lk);
    check("state", align_state_o, e_state);
    check("bnd_excl", faw_boundary_o & crc_boundary_o, 0);
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    check("lock_loss_cnt", lock_loss_cnt_o, m_lost);
    check("faw_miss_cnt", faw_miss_cnt_o, m_fmiss);
`endif
    if (locked_o === 1'b1 && prev_lk !== 1'b1) last_rise = idx;
    if (locked_o === 1'b0 && prev_lk === 1'b1) last_fall = idx;
    prev_lk = locked_o;
  endtask

  function automatic logic [63:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] bad_faw();
    logic [63:0] one;
    one = 64'd1;
    return QECIPHY_FAW ^ (one << $urandom_range(63));
  endfunction

  task automatic do_reset();
    step(-1, '0, 1'b0, 1'b1);
    step(-1, '0, 1'b0, 1'b1);
    last_rise = -1;
    last_fall = -1;
    prev_lk   = 1'b0;
  endtask

  // FAWs at first+64k, frames c_lo..c_hi corrupted, optional fake FAW,
  // relock pulse and reset pulse at given word indices.
  task automatic run(input int first, input int len, input int fake, input int c_lo,
                     input int c_hi, input int relock_at, input int rst_at);
    logic [63:0] w;
    int k;
    do_reset();
    for (int i = 0; i < len; i++) begin
      w = rnd_word();
      if (i >= first && (i - first) % FL == 0) begin
        k = (i - first) / FL;
        w = (k >= c_lo && k <= c_hi) ? bad_faw() : QECIPHY_FAW;
      end
      if (i == fake) w = QECIPHY_FAW;
      step(i, w, (i == relock_at), (i == rst_at));
    end
  endtask

  initial begin
    // Clean stream: third FAW (word 138) confirms lock
    run(10, 210, -1, 99, -1, -1, -1);
    check("s1_lock_word", last_rise, 138);

    // Fake FAW derails first verify; lock on 84/148/212
    run(20, 280, 5, 99, -1, -1, -1);
    check("s2_lock_word", last_rise, 212);

    // Three bad FAWs then a good one: lock held
    run(0, 450, -1, 3, 5, -1, -1);
    check("s3_lock_word", last_rise, 128);
    check("s3_no_drop", last_fall, -1);
    check("s3_still_locked", locked_o, 1);

    // Four bad FAWs: drop after the 4th (word 384)
    run(0, 420, -1, 3, 6, -1, -1);
    check("s4_drop_word", last_fall, 385);
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    check("s4_lock_loss", lock_loss_cnt_o, 1);
    check("s4_faw_miss", faw_miss_cnt_o, 4);
`endif

    // Relock coincides with confirming FAW (word 131)
    run(3, 160, -1, 99, -1, 131, -1);
    check("s5_never_locked", last_rise, -1);
    check("s5_hunt", align_state_o, 0);

    // Reset while locked; relock on 199/263/327
    run(7, 340, -1, 99, -1, -1, 150);
    check("s6_drop_word", last_fall, 150);
    check("s6_relock_word", last_rise, 327);

    // Random corruption, stray FAWs and relock pulses
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] w;
      if (i % FL == 5) w = ($urandom_range(7) == 0) ? bad_faw() : QECIPHY_FAW;
      else             w = ($urandom_range(499) == 0) ? QECIPHY_FAW : rnd_word();
      step(i, w, ($urandom_range(299) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
